data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder serving the MEM-stage load/store requests of the pipelined datapath. It accepts one request at a time from the EX/MEM pipeline outputs, holds the pipeline with `Stall` for a configurable latency, then completes the access with a one-cycle `Ack`. It performs byte and halfword lane selection and sign extension internally. It replaces the single-cycle combinational data memory.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; must be a power of two.
- `LATENCY`, 2: cycles from request acceptance to `Ack`; legal range 1..15.
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Rst`  in  1  reset; asynchronous, active-low.
- `MemRead`  in  1  load request. Held stable while `Stall`=1.
- `MemWrite`  in  1  store request. Held stable while `Stall`=1.
- `Address`  in  32  byte address (`MEM_ALUResult`).
- `WriteData`  in  32  store data (`MEM_ReadData2`). Byte and half stores use the low bits.
- `Datatype`  in  2  access size: 00 = word, 01 = halfword, 10 = byte, 11 = word.
- `ReadData`  out  32  load result. Valid only while `Ack`=1.
- `Stall`  out  1  freezes the PC and every pipeline register while high.
- `Ack`  out  1  one-cycle completion pulse.
- `Err`  out  1  one-cycle pulse, coincident with `Ack`, for a misaligned access.

## Operation
- FSM states are IDLE, BUSY and DONE.
- **IDLE**
  - A request (`MemRead|MemWrite`) is accepted on this edge.
  - Captured into internal registers: `Address`, `WriteData`, `Datatype`, and a write flag.
  - `Stall` is driven combinationally high in the same cycle.
  - Next state is BUSY if `LATENCY`>1, otherwise DONE.
  - The countdown counter loads `LATENCY`-2.
- **BUSY**
  - `Stall`=1.
  - The counter decrements each cycle. At 0 the FSM moves to DONE.
  - On that transition edge a read registers the array word into `ReadData`, after lane select and extension.
- **DONE**
  - `Stall`=0, `Ack`=1.
  - A write updates the array on the edge leaving DONE.
  - Next state is always IDLE.
  - The pipeline advances on that same edge, so the next request is first seen in IDLE.
- **Word index:** `Address[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so accesses wrap modulo the array size.
- **Byte lanes (little-endian):** offset 0 is bits [7:0]; offset 3 is bits [31:24].
- **Loads**
  - Byte loads sign-extend bit 7 of the selected lane.
  - Halfword loads sign-extend bit 15 of the selected half.
- **Stores**
  - A byte store writes only the addressed lane, taken from `WriteData[7:0]`.
  - A halfword store writes only the addressed half, taken from `WriteData[15:0]`.
  - All other bytes are preserved.
- **Misalignment**
  - Misaligned means a word access with `Address[1:0]`≠0, or a halfword access with `Address[0]`≠0.
  - The request still walks through the full latency.
  - No array write occurs and `ReadData`=0.
  - `Err`=1 together with `Ack`.
- **Simultaneous `MemRead` and `MemWrite`:** the access is treated as a write and the read is ignored.
- **Reset**
  - Reset may be asserted at any point, including mid-operation.
  - State returns to IDLE. `Stall`=0, `Ack`=0, `Err`=0, `ReadData`=0, and the counter is 0.
  - A pending write is discarded. Array contents are not cleared.

## Timing
- Call the cycle a request is first seen in IDLE cycle 0.
- `Ack` and `ReadData` are valid in cycle `LATENCY`. `Stall` is high for cycles 0..`LATENCY`-1.
- Total pipeline hold is exactly `LATENCY` cycles per memory access. Non-memory cycles incur no stall.
- Store data is visible to a load accepted in any later cycle. Back-to-back store→load of the same address returns the new value.
- `Stall` is the only combinational output, decoded from the FSM state and the request inputs. All other outputs are registered.

## Test plan
- **Word store then load, `LATENCY`=2:**
  - Store 0xDEADBEEF to address 0x10.
  - Required: `Stall` high for 2 cycles and `Ack` in cycle 2.
  - Load 0x10: `ReadData`=0xDEADBEEF with `Ack` in cycle 2.
- **Byte and half lanes:**
  - Word 0x11223344 at 0x20, then byte-store 0xAA to 0x22.
  - Word load returns 0x11AA3344.
  - Byte load 0x23 returns 0x00000011.
  - Half load 0x22 returns 0x000011AA.
- **Sign extension:**
  - Word 0x0000F080 at 0x30.
  - Byte load 0x30 returns 0xFFFFFF80.
  - Half load 0x30 returns 0xFFFFF080.
- **Misaligned:**
  - Word store 0x12345678 to 0x41: `Err`=1 with `Ack` and no array change.
  - Half load 0x43: `Err`=1 and `ReadData`=0.
- **Reset mid-operation:**
  - Drop `Rst` during BUSY of a store of 0x55 to 0x50.
  - Required: immediate `Stall`=0 and `Ack`=0; a word load of 0x50 afterwards returns the previous contents.
- **Wrap and latency limits:**
  - With `DEPTH_WORDS`=1024, store to 0x1004, then load 0x0004: returns the same word.
  - Repeat with `LATENCY`=1: `Stall` for exactly 1 cycle.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: holds the pipeline for LATENCY cycles,
// then completes with a one-cycle Ack carrying the lane-selected, sign-extended load result.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Datatype,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Ack,
  output logic        Err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         ack_q, ack_d;
  logic         err_q, err_d;
  logic [31:0]  rdata_q, rdata_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [1:0]   dtype_q, dtype_d;
  logic         wr_q, wr_d;

  logic [31:0]  mem [DEPTH_WORDS];

  logic          req;
  logic          finish;
  logic          mis;
  logic [31:0]   cur_addr;
  logic [1:0]    cur_dtype;
  logic          cur_wr;
  logic [AW-1:0] cur_idx;
  logic [AW-1:0] done_idx;
  logic          mem_we;

  function automatic logic misaligned(input logic [1:0] off, input logic [1:0] dt);
    case (dt)
      2'b01:   return off[0];
      2'b10:   return 1'b0;
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] load_lane(input logic [31:0] word, input logic [1:0] off,
                                            input logic [1:0] dt);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (dt)
      2'b01:   return {{16{sh[15]}}, sh[15:0]};
      2'b10:   return {{24{sh[7]}}, sh[7:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] off, input logic [1:0] dt);
    logic [31:0] mask;
    case (dt)
      2'b01:   mask = 32'h0000_FFFF;
      2'b10:   mask = 32'h0000_00FF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << {off, 3'b000};
    return (old & ~mask) | ((wd << {off, 3'b000}) & mask);
  endfunction

  assign req = MemRead | MemWrite;

  // In IDLE the live inputs are the request, so LATENCY=1 can complete on the accept edge.
  assign cur_addr  = (state_q == IDLE) ? Address  : addr_q;
  assign cur_dtype = (state_q == IDLE) ? Datatype : dtype_q;
  assign cur_wr    = (state_q == IDLE) ? MemWrite : wr_q;
  assign cur_idx   = AW'(cur_addr >> 2);
  assign done_idx  = AW'(addr_q >> 2);
  assign mis       = misaligned(cur_addr[1:0], cur_dtype);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dtype_d = dtype_q;
    wr_d    = wr_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = 32'h0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = Address;
          wdata_d = WriteData;
          dtype_d = Datatype;
          wr_d    = MemWrite;
          cnt_d   = CNT_INIT;
          if (LATENCY > 1) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            finish  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (finish) begin
      ack_d = 1'b1;
      err_d = mis;
      if (!cur_wr && !mis) rdata_d = load_lane(mem[cur_idx], cur_addr[1:0], cur_dtype);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge Clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    dtype_q <= dtype_d;
  end

  // Stores commit on the edge leaving DONE, together with the pipeline advance.
  assign mem_we = Rst && (state_q == DONE) && wr_q && !err_q;

  always_ff @(posedge Clk) begin
    if (mem_we) mem[done_idx] <= store_merge(mem[done_idx], wdata_q, addr_q[1:0], dtype_q);
  end

  assign Stall    = Rst && (((state_q == IDLE) && req) || (state_q == BUSY));
  assign Ack      = ack_q;
  assign Err      = err_q;
  assign ReadData = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder at LATENCY=2 and LATENCY=1 against a byte-level memory model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT0  = 2;
  localparam int LAT1  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [1:0]  dt    [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        ack   [2];
  logic        err   [2];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_lat2 (
    .Clk(clk), .Rst(rst_n), .MemRead(rd[0]), .MemWrite(wr[0]), .Address(addr[0]),
    .WriteData(wd[0]), .Datatype(dt[0]), .ReadData(rdata[0]), .Stall(stall[0]),
    .Ack(ack[0]), .Err(err[0]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_lat1 (
    .Clk(clk), .Rst(rst_n), .MemRead(rd[1]), .MemWrite(wr[1]), .Address(addr[1]),
    .WriteData(wd[1]), .Datatype(dt[1]), .ReadData(rdata[1]), .Stall(stall[1]),
    .Ack(ack[1]), .Err(err[1]));

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [2][DEPTH];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %08h want %08h", name, act, want);
    end
  endtask

  function automatic int size_of(input logic [1:0] t);
    if (t == 2'b01) return 2;
    if (t == 2'b10) return 1;
    return 4;
  endfunction

  function automatic bit is_misaligned(input logic [31:0] a, input logic [1:0] t);
    return (a % size_of(t)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input int inst, input logic [31:0] a, input logic [1:0] t);
    logic [31:0] w;
    logic [31:0] v;
    int n;
    int off;
    w   = model[inst][(a >> 2) % DEPTH];
    off = int'(a % 4);
    n   = size_of(t);
    v   = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
    if (n < 4 && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic ref_store(input int inst, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] t);
    logic [31:0] w;
    int off;
    w   = model[inst][(a >> 2) % DEPTH];
    off = int'(a % 4);
    for (int i = 0; i < size_of(t); i++) w[8*(off+i) +: 8] = d[8*i +: 8];
    model[inst][(a >> 2) % DEPTH] = w;
  endtask

  task automatic compare_pop(input int inst);
    exp_t e;
    int   sz;
    sz = (inst == 0) ? q0.size() : q1.size();
    checks++;
    if (sz == 0) begin
      failures++;
      $display("FAIL ack_unexpected_u%0d: got Ack=1 want no pending request", inst);
    end else begin
      e = (inst == 0) ? q0.pop_front() : q1.pop_front();
      if (e.chk_data) check($sformatf("rdata_u%0d", inst), rdata[inst], e.data);
      check($sformatf("err_u%0d", inst), {31'h0, err[inst]}, {31'h0, e.err});
    end
  endtask

  always @(negedge clk) begin
    if (ack[0] === 1'b1) compare_pop(0);
    if (ack[1] === 1'b1) compare_pop(1);
  end

  // Issue one access at a negedge; returns at the negedge after the Ack cycle.
  task automatic access(input int inst, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] t);
    exp_t e;
    int   lat;
    int   k;
    int   stalls;
    bit   got;
    bit   m;
    lat        = (inst == 0) ? LAT0 : LAT1;
    m          = is_misaligned(a, t);
    e.err      = m;
    e.chk_data = !w || m;
    e.data     = (!w && !m) ? ref_load(inst, a, t) : 32'h0;
    if (inst == 0) q0.push_back(e); else q1.push_back(e);
    if (w && !m) ref_store(inst, a, d, t);
    rd[inst] = r; wr[inst] = w; addr[inst] = a; wd[inst] = d; dt[inst] = t;
    k = 0; stalls = 0; got = 0;
    while (!got && k <= 20) begin
      #1;
      if (ack[inst] === 1'b1) begin
        got = 1;
        check($sformatf("stall_in_ack_u%0d", inst), {31'h0, stall[inst]}, 32'h0);
      end else begin
        if (stall[inst] === 1'b1) stalls++;
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL ack_timeout_u%0d: got no Ack in %0d cycles want Ack in cycle %0d", inst, k, lat);
    end else begin
      check($sformatf("ack_cycle_u%0d", inst), k, lat);
      check($sformatf("stall_cycles_u%0d", inst), stalls, lat);
    end
    @(negedge clk);
    rd[inst] = 1'b0; wr[inst] = 1'b0;
  endtask

  task automatic idle(input int inst, input int n);
    bit bad;
    bad = 0;
    rd[inst] = 1'b0; wr[inst] = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (stall[inst] !== 1'b0) bad = 1;
      @(negedge clk);
    end
    check($sformatf("idle_no_stall_u%0d", inst), {31'h0, bad}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] old;
    logic [31:0] a;
    bit          r;
    bit          w;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'h0; wd[i] = 32'h0; dt[i] = 2'b00;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_stall_u%0d", i), {31'h0, stall[i]}, 32'h0);
      check($sformatf("reset_ack_u%0d", i), {31'h0, ack[i]}, 32'h0);
      check($sformatf("reset_err_u%0d", i), {31'h0, err[i]}, 32'h0);
      check($sformatf("reset_rdata_u%0d", i), rdata[i], 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 32; j++) access(i, 0, 1, j * 4, $urandom, 2'b00);

    access(0, 0, 1, 32'h10, 32'hDEADBEEF, 2'b00);
    access(0, 1, 0, 32'h10, 32'h0, 2'b00);
    access(0, 0, 1, 32'h20, 32'h11223344, 2'b00);
    access(0, 0, 1, 32'h22, 32'h000000AA, 2'b10);
    access(0, 1, 0, 32'h20, 32'h0, 2'b00);
    access(0, 1, 0, 32'h23, 32'h0, 2'b10);
    access(0, 1, 0, 32'h22, 32'h0, 2'b01);
    access(0, 0, 1, 32'h30, 32'h0000F080, 2'b11);
    access(0, 1, 0, 32'h30, 32'h0, 2'b10);
    access(0, 1, 0, 32'h30, 32'h0, 2'b01);
    access(0, 0, 1, 32'h41, 32'h12345678, 2'b00);
    access(0, 1, 0, 32'h40, 32'h0, 2'b00);
    access(0, 1, 0, 32'h43, 32'h0, 2'b01);
    access(0, 1, 1, 32'h44, 32'hCAFEF00D, 2'b00);
    access(0, 1, 0, 32'h44, 32'h0, 2'b00);

    old = model[0][20];
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h50; wd[0] = 32'h55; dt[0] = 2'b00;
    @(negedge clk);
    #1;
    check("busy_stall_before_reset", {31'h0, stall[0]}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midreset_stall", {31'h0, stall[0]}, 32'h0);
    check("midreset_ack", {31'h0, ack[0]}, 32'h0);
    wr[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("model_kept_old_word", model[0][20], old);
    access(0, 1, 0, 32'h50, 32'h0, 2'b00);

    for (int i = 0; i < 2; i++) begin
      access(i, 0, 1, 32'h1004, 32'hA5A55A5A, 2'b00);
      access(i, 1, 0, 32'h0004, 32'h0, 2'b00);
      idle(i, 2);
    end

    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 150; n++) begin
        r = 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
        if (!r && !w) idle(i, $urandom_range(1, 3));
        else access(i, r, w, a, $urandom, 2'($urandom_range(0, 3)));
      end
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty_u0", q0.size(), 0);
    check("scoreboard_empty_u1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
